fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 13, instruction address width; matches the execute-stage jump-address width.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 13'd0, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 stall  in  1  hazard hold: freeze IF/ID outputs and PC.
REQ-007 branch_taken  in  1  redirect request from the execute stage.
REQ-008 jaddr  in  ADDR_W  redirect target; driven from the execute stage's jaddr_out.
REQ-009 imem_req  out  1  instruction-memory read strobe.
REQ-010 imem_addr  out  ADDR_W  read address, registered.
REQ-011 imem_rdata  in  INSTR_W  word for the address requested in the previous cycle; synchronous 1-cycle memory.
REQ-012 if_valid  out  1  IF/ID register holds a live instruction.
REQ-013 if_pc  out  ADDR_W  address of if_instr.
REQ-014 if_instr  out  INSTR_W  IF/ID instruction word.

Function
REQ-015 State machine SHALL have states FETCH and HALTED.
REQ-016 In FETCH with stall=0 and branch_taken=0, the unit SHALL set imem_req=1 and imem_addr=pc, and SHALL increment pc by 1 each cycle.
REQ-017 The pc increment SHALL wrap modulo 2^ADDR_W; 13'h1FFF SHALL be followed by 13'h0000.
REQ-018 A word requested in cycle N SHALL be captured into IF/ID at the end of cycle N+1, with if_valid=1 in cycle N+2; fetch-to-decode latency is 2 cycles, throughput 1 per cycle.
REQ-019 The unit SHALL track each outstanding request with an in-flight flag plus its address, so that if_pc always equals the address whose word is in if_instr.
REQ-020 With stall=1, the unit SHALL hold if_valid, if_pc, if_instr and pc, and SHALL drive imem_req=0.
REQ-021 If a word returns while stall=1, the unit SHALL capture it with its address in a 1-entry skid buffer; no word SHALL be lost or duplicated.
REQ-022 On stall release with the skid buffer full, IF/ID SHALL load from the skid buffer first, the buffer SHALL empty, and fetch SHALL resume at the held pc in the same cycle.
REQ-023 branch_taken=1 SHALL take priority over stall and over halt.
REQ-024 On branch_taken=1, the unit SHALL load pc with jaddr, discard the in-flight word, and clear the skid buffer.
REQ-025 On branch_taken=1, the unit SHALL set if_valid=0 in the next cycle (flush), drive imem_addr=jaddr with imem_req=1 in the next cycle, and enter FETCH.
REQ-026 HALT encoding is if_instr[INSTR_W-1:INSTR_W-4]==4'hF.
REQ-027 When a HALT word is loaded into IF/ID, the unit SHALL enter HALTED.
REQ-028 In HALTED, imem_req SHALL be 0 and pc SHALL hold; the HALT word SHALL be presented for one unstalled cycle, after which if_valid=0.
REQ-029 HALTED SHALL exit only on rst or branch_taken=1.
REQ-030 A word returning for a request issued before HALT entry SHALL be discarded.
REQ-031 branch_taken and stall asserted in the same cycle SHALL behave as branch_taken alone; stall SHALL apply from the next cycle, with the redirected word then going to the skid buffer.

Reset
REQ-032 While rst=1, the unit SHALL set pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, skid buffer empty, in-flight flag clear, state FETCH.
REQ-033 The first imem_req=1 with imem_addr=RESET_PC SHALL occur in the first cycle after rst falls.
REQ-034 rst asserted mid-operation, including during stall, HALTED, or a redirect, SHALL override all other inputs and discard in-flight data.

Verification
REQ-035 Sequential: rst 5 cycles then release, memory mem[a]=a+32'h100 -> if_valid=1 from 2 cycles after the first request with (if_pc, if_instr)=(0,0x100),(1,0x101),(2,0x102), one per cycle, no gaps.
REQ-036 Stall: stall=1 for 3 cycles while the word for address 4 is in flight -> outputs frozen; after release if_pc sequence continues 4,5,6 with no duplicate and no skip.
REQ-037 Branch: branch_taken=1 with jaddr=13'd1500 while address 7 is in flight -> if_valid=0 for the flush cycle; next valid if_pc=1500, then 1501; word 7 is never presented.
REQ-038 Simultaneous branch_taken=1 with stall=1, jaddr=13'd20 -> redirect honoured; if_pc=20 appears after stall drops.
REQ-039 Wrap and halt: start at jaddr=13'h1FFE, mem[0]=32'hF000_0000 -> if_pc 1FFE, 1FFF, 0; HALT held for one cycle, then if_valid=0 and imem_req=0 until branch_taken or rst.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and a synchronous 1-cycle memory.
// master: imem_req/imem_addr out, imem_rdata in; slave: the mirror image.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, 1-cycle memory, IF/ID register, skid, HALT.
// Ports: clk, rst, stall, branch_taken, jaddr in; imem bus (master); if_valid/if_pc/if_instr out.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 13,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  jaddr,
    fetch_unit_if.master       imem,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    typedef enum logic {S_FETCH, S_HALTED} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q;
    logic               redir_q;
    logic               rv_q;
    logic [ADDR_W-1:0]  rv_addr_q;
    logic               skid_v_q;
    logic [ADDR_W-1:0]  skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic               if_valid_q;
    logic [ADDR_W-1:0]  if_pc_q;
    logic [INSTR_W-1:0] if_instr_q;

    logic               fetching;
    logic               issue;
    logic               load_skid;
    logic               load_mem;
    logic               to_skid;
    logic               is_halt;
    logic [ADDR_W-1:0]  load_pc;
    logic [INSTR_W-1:0] load_instr;

    // The cycle right after a redirect always issues the target, even under
    // stall, so the redirected word can land in the skid buffer.
    always_comb begin
        fetching   = (state_q == S_FETCH);
        issue      = fetching && (!stall || redir_q);
        load_skid  = fetching && !stall && skid_v_q;
        load_mem   = fetching && !stall && !skid_v_q && rv_q;
        to_skid    = fetching && stall && rv_q;
        load_instr = load_skid ? skid_instr_q : imem.imem_rdata;
        load_pc    = load_skid ? skid_pc_q : rv_addr_q;
        is_halt    = (load_skid || load_mem)
                   && (load_instr[INSTR_W-1 -: 4] == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = S_FETCH;
        end else if (is_halt) begin
            state_d = S_HALTED;
        end
    end

    always_comb begin
        imem.imem_req = !rst && issue;
    end

    assign imem.imem_addr = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;

    // rv_q marks that imem_rdata this cycle belongs to rv_addr_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            redir_q      <= 1'b0;
            rv_q         <= 1'b0;
            rv_addr_q    <= '0;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
        end else if (branch_taken) begin
            pc_q       <= jaddr;
            redir_q    <= 1'b1;
            rv_q       <= 1'b0;
            skid_v_q   <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            redir_q <= 1'b0;
            rv_q    <= issue;
            if (issue) begin
                rv_addr_q <= pc_q;
                pc_q      <= pc_q + ADDR_W'(1);
            end
            if (to_skid) begin
                skid_v_q     <= 1'b1;
                skid_pc_q    <= rv_addr_q;
                skid_instr_q <= imem.imem_rdata;
            end else if (load_skid) begin
                skid_v_q <= 1'b0;
            end
            if (load_skid || load_mem) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= load_pc;
                if_instr_q <= load_instr;
            end else if (!stall) begin
                if_valid_q <= 1'b0;
            end
        end
    end

endmodule
